dmem_arbiter: RTL and testbench

// - Shares the single byte-addressed data memory (0x00000-0x1FFFF, combinational read, clocked write)

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 33 +++
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    localparam logic MEMTYPE_BYTE = 1'b1;
    localparam logic MEMTYPE_WORD = 1'b0;

    // Top of the 128 KiB data memory window.
    localparam logic [31:0] DEFAULT_ADDR_MAX = 32'h0001_FFFF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// port that did not win last time is granted. History advances only on en.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_grant;

    // Combinational one-hot grant from current requests and grant history.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Grant history; reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (en) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one byte-addressed data memory between the CPU LSU (port 0) and a
// loader/debug port (port 1). One transaction at a time:
// IDLE (handshake) -> ACCESS (single memory cycle) -> RESP (held until taken).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ADDR_MAX = WIDTH'(DEFAULT_ADDR_MAX)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             p0_req_valid,
    output logic             p0_req_ready,
    input  logic             p0_we,
    input  logic             p0_memtype,
    input  logic [WIDTH-1:0] p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic             p0_resp_valid,
    input  logic             p0_resp_ready,
    output logic [WIDTH-1:0] p0_rdata,
    output logic             p0_err,

    input  logic             p1_req_valid,
    output logic             p1_req_ready,
    input  logic             p1_we,
    input  logic             p1_memtype,
    input  logic [WIDTH-1:0] p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic             p1_resp_valid,
    input  logic             p1_resp_ready,
    output logic [WIDTH-1:0] p1_rdata,
    output logic             p1_err,

    output logic             mem_we,
    output logic             mem_memtype,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    // A word touches addr..addr+3, so its last legal start is ADDR_MAX-3.
    function automatic logic range_err(input logic mt, input logic [WIDTH-1:0] a);
        if (mt == MEMTYPE_BYTE) begin
            return a > ADDR_MAX;
        end
        return a > (ADDR_MAX - WIDTH'(3));
    endfunction

    // Byte loads are zero-extended from the low lane.
    function automatic logic [WIDTH-1:0] load_data(input logic mt, input logic [WIDTH-1:0] rd);
        if (mt == MEMTYPE_BYTE) begin
            return {{(WIDTH-8){1'b0}}, rd[7:0]};
        end
        return rd;
    endfunction

    arb_state_t       state;
    arb_state_t       state_next;
    logic [1:0]       gnt;
    logic             handshake;
    logic             owner_resp_ready;

    logic             sel_we;
    logic             sel_memtype;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;

    logic             req_port_p1;
    logic             req_err_p1;
    logic             req_we_p1;
    logic             req_memtype_p1;
    logic [WIDTH-1:0] req_addr_p1;
    logic [WIDTH-1:0] req_wdata_p1;

    logic             resp_err_p2;
    logic [WIDTH-1:0] resp_rdata_p2;

    rr_arbiter2 u_rr (
        .clk (clk),
        .rst (rst),
        .req ({p1_req_valid, p0_req_valid}),
        .en  (handshake),
        .gnt (gnt)
    );

    assign handshake        = (state == IDLE) && !rst && (gnt != 2'b00);
    assign owner_resp_ready = req_port_p1 ? p1_resp_ready : p0_resp_ready;

    assign sel_we      = gnt[1] ? p1_we      : p0_we;
    assign sel_memtype = gnt[1] ? p1_memtype : p0_memtype;
    assign sel_addr    = gnt[1] ? p1_addr    : p0_addr;
    assign sel_wdata   = gnt[1] ? p1_wdata   : p0_wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and all handshake / memory-side outputs.
    always_comb begin
        state_next    = state;
        p0_req_ready  = 1'b0;
        p1_req_ready  = 1'b0;
        p0_resp_valid = 1'b0;
        p1_resp_valid = 1'b0;
        p0_rdata      = '0;
        p1_rdata      = '0;
        p0_err        = 1'b0;
        p1_err        = 1'b0;
        mem_we        = 1'b0;
        mem_memtype   = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state)
            IDLE: begin
                p0_req_ready = gnt[0] & ~rst;
                p1_req_ready = gnt[1] & ~rst;
                if (handshake) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_we      = req_we_p1 & ~req_err_p1 & ~rst;
                mem_memtype = req_memtype_p1;
                mem_addr    = req_addr_p1;
                mem_wdata   = req_wdata_p1;
                state_next  = RESP;
            end
            RESP: begin
                if (req_port_p1) begin
                    p1_resp_valid = 1'b1;
                    p1_rdata      = resp_rdata_p2;
                    p1_err        = resp_err_p2;
                end else begin
                    p0_resp_valid = 1'b1;
                    p0_rdata      = resp_rdata_p2;
                    p0_err        = resp_err_p2;
                end
                if (owner_resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage 1: request register, loaded on the accepting handshake.
    always_ff @(posedge clk) begin
        if (handshake) begin
            req_port_p1    <= gnt[1];
            req_err_p1     <= range_err(sel_memtype, sel_addr);
            req_we_p1      <= sel_we;
            req_memtype_p1 <= sel_memtype;
            req_addr_p1    <= sel_addr;
            req_wdata_p1   <= sel_wdata;
        end
    end

    // Stage 2: response register, captured at the end of the ACCESS cycle.
    always_ff @(posedge clk) begin
        if (state == ACCESS) begin
            resp_err_p2   <= req_err_p1;
            resp_rdata_p2 <= (req_we_p1 || req_err_p1) ? '0
                                                       : load_data(req_memtype_p1, mem_rdata);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req_valid, p0_req_ready, p0_we, p0_memtype;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p0_resp_valid, p0_resp_ready, p0_err;
    logic        p1_req_valid, p1_req_ready, p1_we, p1_memtype;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        p1_resp_valid, p1_resp_ready, p1_err;
    logic        mem_we, mem_memtype;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int we_count = 0;

    logic [7:0]  mem [0:131071] = '{default: 8'h00};
    logic [16:0] ia0, ia1, ia2, ia3;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
        .p0_memtype(p0_memtype), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
        .p1_memtype(p1_memtype), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_memtype(mem_memtype), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: combinational little-endian read, clocked write.
    assign ia0 = mem_addr[16:0];
    assign ia1 = mem_addr[16:0] + 17'd1;
    assign ia2 = mem_addr[16:0] + 17'd2;
    assign ia3 = mem_addr[16:0] + 17'd3;
    assign mem_rdata = mem_memtype ? {24'h0, mem[ia0]}
                                   : {mem[ia3], mem[ia2], mem[ia1], mem[ia0]};

    always @(posedge clk) begin
        if (mem_we) begin
            we_count <= we_count + 1;
            mem[ia0] <= mem_wdata[7:0];
            if (!mem_memtype) begin
                mem[ia1] <= mem_wdata[15:8];
                mem[ia2] <= mem_wdata[23:16];
                mem[ia3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic v, input logic we, input logic mt,
                         input logic [31:0] a, input logic [31:0] wd);
        if (port == 0) begin
            p0_req_valid = v; p0_we = we; p0_memtype = mt; p0_addr = a; p0_wdata = wd;
        end else begin
            p1_req_valid = v; p1_we = we; p1_memtype = mt; p1_addr = a; p1_wdata = wd;
        end
    endtask

    task automatic wait_ready(input int port, output logic rdy);
        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            rdy = (port == 0) ? p0_req_ready : p1_req_ready;
            if (rdy === 1'b1) return;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic xact(input string tag, input int port, input logic we, input logic mt,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        logic rdy;
        p0_resp_ready = 1'b1;
        p1_resp_ready = 1'b1;
        drive(port, 1'b1, we, mt, a, wd);
        wait_ready(port, rdy);
        chk({tag, "_ready"}, {31'h0, rdy}, 32'h1);
        tick();
        drive(port, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk({tag, "_acc_rv"}, {31'h0, (port == 0) ? p0_resp_valid : p1_resp_valid}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, {31'h0, we & ~exp_err});
        tick();
        chk({tag, "_rv"},    {31'h0, (port == 0) ? p0_resp_valid : p1_resp_valid}, 32'h1);
        chk({tag, "_rdata"}, (port == 0) ? p0_rdata : p1_rdata, exp_rd);
        chk({tag, "_err"},   {31'h0, (port == 0) ? p0_err : p1_err}, {31'h0, exp_err});
        tick();
    endtask

    initial begin
        logic rdy;
        int   wc;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        p0_resp_ready = 1'b0;
        p1_resp_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_p0_ready", {31'h0, p0_req_ready}, 32'h0);
        chk("rst_p1_ready", {31'h0, p1_req_ready}, 32'h0);
        chk("rst_p0_rv",    {31'h0, p0_resp_valid}, 32'h0);
        chk("rst_p1_rv",    {31'h0, p1_resp_valid}, 32'h0);
        chk("rst_p0_rdata", p0_rdata, 32'h0);
        chk("rst_p0_err",   {31'h0, p0_err}, 32'h0);
        chk("rst_mem_we",   {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        tick();

        // Basic word store then load on port 0.
        xact("st_word", 0, 1'b1, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xact("ld_word", 0, 1'b0, 1'b0, 32'h0001_0000, 32'h0, 32'hDEAD_BEEF, 1'b0);
        // Byte load on port 1 from the stored word.
        xact("ld_byte", 1, 1'b0, 1'b1, 32'h0001_0001, 32'h0, 32'h0000_00BE, 1'b0);
        chk("we_count_1", we_count, 32'd1);

        // Round robin with both ports requesting continuously.
        do_reset();
        p0_resp_ready = 1'b1;
        p1_resp_ready = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 10; i++) begin
                #1;
                if (p0_req_ready || p1_req_ready) break;
                tick();
            end
            chk($sformatf("rr_grant_%0d", k), {30'h0, p1_req_ready, p0_req_ready},
                (k % 2 == 1) ? 32'h2 : 32'h1);
            tick();
            if (k == 3) begin
                drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        tick();
        tick();

        // Range boundaries.
        xact("st_word_oor",  0, 1'b1, 1'b0, 32'h0001_FFFE, 32'h1122_3344, 32'h0, 1'b1);
        chk("we_count_oor", we_count, 32'd1);
        xact("st_byte_last", 0, 1'b1, 1'b1, 32'h0001_FFFF, 32'h0000_00A5, 32'h0, 1'b0);
        chk("we_count_2", we_count, 32'd2);
        chk("mem_1ffff", {24'h0, mem[17'h1FFFF]}, 32'hA5);
        chk("mem_1fffe", {24'h0, mem[17'h1FFFE]}, 32'h00);
        xact("ld_word_top",  1, 1'b0, 1'b0, 32'h0001_FFFC, 32'h0, 32'hA500_0000, 1'b0);
        xact("ld_byte_oor",  1, 1'b0, 1'b1, 32'h0002_0000, 32'h0, 32'h0, 1'b1);
        xact("ld_misalign",  0, 1'b0, 1'b0, 32'h0001_0001, 32'h0, 32'h00DE_ADBE, 1'b0);

        // Response back-pressure on port 1 while port 0 waits.
        p1_resp_ready = 1'b0;
        p0_resp_ready = 1'b1;
        drive(1, 1'b1, 1'b0, 1'b1, 32'h0001_0000, 32'h0);
        wait_ready(1, rdy);
        chk("bp_p1_ready", {31'h0, rdy}, 32'h1);
        tick();
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0);
        #1;
        chk("bp_acc_p0_ready", {31'h0, p0_req_ready}, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_rv_%0d", i),    {31'h0, p1_resp_valid}, 32'h1);
            chk($sformatf("bp_rdata_%0d", i), p1_rdata, 32'h0000_00EF);
            chk($sformatf("bp_p0rdy_%0d", i), {31'h0, p0_req_ready}, 32'h0);
            tick();
        end
        p1_resp_ready = 1'b1;
        #1;
        chk("bp_release_p0rdy", {31'h0, p0_req_ready}, 32'h0);
        tick();
        chk("bp_after_p0rdy", {31'h0, p0_req_ready}, 32'h1);
        chk("bp_after_p1rv",  {31'h0, p1_resp_valid}, 32'h0);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("bp_p0_rv",    {31'h0, p0_resp_valid}, 32'h1);
        chk("bp_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
        tick();

        // Reset during the ACCESS cycle of a store.
        wc = we_count;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0001_0008, 32'h5566_7788);
        wait_ready(0, rdy);
        chk("rst_st_ready", {31'h0, rdy}, 32'h1);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        chk("rst_acc_mem_we", {31'h0, mem_we}, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rst_abort_rv_%0d", i), {30'h0, p1_resp_valid, p0_resp_valid}, 32'h0);
            chk($sformatf("rst_abort_we_%0d", i), {31'h0, mem_we}, 32'h0);
            tick();
        end
        chk("rst_abort_wecnt", we_count, wc);
        chk("rst_abort_mem", {mem[17'h1000B], mem[17'h1000A], mem[17'h10009], mem[17'h10008]},
            32'h0);
        // Arbiter still usable after the abort.
        xact("post_rst_ld", 0, 1'b0, 1'b0, 32'h0001_0000, 32'h0, 32'hDEAD_BEEF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
